// File: rtl/proc_buf_pkg.sv
// proc_buf_pkg: shared defaults and statistics widths for the processor output buffer
package proc_buf_pkg;
    localparam int DATA_W_DEF = 8;
    localparam int DEPTH_DEF = 8;
    localparam int DROP_CNT_W = 8;
    localparam logic [DROP_CNT_W-1:0] DROP_CNT_MAX = 8'hFF;
endpackage

// File: rtl/proc_buf_mem.sv
// proc_buf_mem: unreset register array, synchronous write and asynchronous read
module proc_buf_mem
    import proc_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic              clk,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr,
    output logic [DATA_W-1:0] rdata
);
    logic [DATA_W-1:0] mem [DEPTH];
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end
    assign rdata = mem[raddr];
endmodule

// File: rtl/proc_out_buffer.sv
// proc_out_buffer: FWFT elastic buffer after the processor with drop and occupancy statistics
module proc_out_buffer
    import proc_buf_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH = DEPTH_DEF,
    localparam int AW = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [DATA_W-1:0]     out_data,
    output logic [AW:0]           count,
    output logic                  full,
    output logic                  empty,
    output logic                  overflow,
    output logic [DROP_CNT_W-1:0] drop_cnt,
    output logic [AW:0]           peak,
    input  logic                  clr_stats
);
    logic [AW:0] wr_ptr, rd_ptr, count_next, peak_next;
    logic [DROP_CNT_W-1:0] drop_cnt_next;
    logic push, pop, drop, overflow_next;

    // pointers carry one extra wrap bit so full and empty stay distinguishable
    assign count = wr_ptr - rd_ptr;
    assign full = count == (AW+1)'(DEPTH);
    assign empty = count == '0;
    assign out_valid = !empty;
    assign pop = out_valid && out_ready;
    assign push = in_valid && (!full || pop);
    assign drop = in_valid && full && !pop;
    assign count_next = count + (AW+1)'(push) - (AW+1)'(pop);

    // a clear coinciding with a drop restarts the statistics at that drop
    always_comb begin
        peak_next = (clr_stats || count_next > peak) ? count_next : peak;
        overflow_next = clr_stats ? drop : (overflow || drop);
        drop_cnt_next = clr_stats ? DROP_CNT_W'(drop) :
                        (drop && drop_cnt != DROP_CNT_MAX) ? drop_cnt + 1'b1 : drop_cnt;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            overflow <= 1'b0;
            drop_cnt <= '0;
            peak <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            overflow <= overflow_next;
            drop_cnt <= drop_cnt_next;
            peak <= peak_next;
        end
    end

    proc_buf_mem #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_mem (
        .clk   (clk),
        .we    (push),
        .waddr (wr_ptr[AW-1:0]),
        .wdata (in_data),
        .raddr (rd_ptr[AW-1:0]),
        .rdata (out_data)
    );
endmodule
